digit_entry_buffer: RTL and testbench

Parametrised keypad entry buffer for the RGB colour-entry path. It collects decimal digit codes from the keypad decoder into an N-digit entry register and shows that entry for the 7-segment display. On an Enter key it converts the entry to binary, range-checks it, and commits it to one of N colour channels. The block sits between the keypad decoder and the PWM/colour generator, and supports multi-channel sequencing and entry editing.

---
 rtl/digit_entry_buffer_pkg.sv | 16 +
 rtl/digit_shift_reg.sv | 46 ++++
 rtl/digit_entry_buffer.sv | 150 +++++++++++++++
 tb/tb_digit_entry_buffer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/digit_entry_buffer_pkg.sv
// Shared key codes and FSM encoding for the keypad digit entry buffer.
package digit_entry_buffer_pkg;

    localparam logic [4:0] KEY_DIGIT_MAX = 5'd9;
    localparam logic [4:0] KEY_BKSP      = 5'd10;
    localparam logic [4:0] KEY_ENTER     = 5'd11;
    localparam logic [4:0] KEY_CANCEL    = 5'd12;
    localparam logic [4:0] KEY_BLANK     = 5'd16;

    typedef enum logic [1:0] {
        S_ENTRY = 2'd0,
        S_CONV  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

endpackage

// File: rtl/digit_shift_reg.sv
// N_DIGITS x 5-bit slot array with digit count; shift-up, clear and (with
// BACKSPACE_EN defined) shift-down. Slot 0 is the units digit.
module digit_shift_reg
    import digit_entry_buffer_pkg::*;
#(
    parameter  int N_DIGITS = 3,
    localparam int CNT_W    = $clog2(N_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    shift_up,
    input  logic [3:0]              digit_in,
`ifdef BACKSPACE_EN
    input  logic                    shift_down,
`endif
    input  logic                    clear,
    output logic [5*N_DIGITS-1:0]   digits,
    output logic [CNT_W-1:0]        count
);

    logic [4:0] slots [N_DIGITS];

    // Callers guarantee shift_up only when not full and shift_down only when non-empty.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < N_DIGITS; i++) slots[i] <= KEY_BLANK;
            count <= '0;
        end else if (shift_up) begin
            for (int i = N_DIGITS - 1; i > 0; i--) slots[i] <= slots[i-1];
            slots[0] <= {1'b0, digit_in};
            count    <= count + CNT_W'(1);
        end
`ifdef BACKSPACE_EN
        else if (shift_down) begin
            for (int i = 0; i < N_DIGITS - 1; i++) slots[i] <= slots[i+1];
            slots[N_DIGITS-1] <= KEY_BLANK;
            count             <= count - CNT_W'(1);
        end
`endif
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_flat
        assign digits[5*g +: 5] = slots[g];
    end

endmodule

// File: rtl/digit_entry_buffer.sv
// Keypad entry buffer: collects decimal digits, converts on Enter, range-checks
// and commits to a round-robin colour channel. Optional macro: BACKSPACE_EN.
module digit_entry_buffer
    import digit_entry_buffer_pkg::*;
#(
    parameter  int N_DIGITS   = 3,
    parameter  int N_CHANNELS = 3,
    parameter  int MAX_VALUE  = 255,
    localparam int CNT_W      = $clog2(N_DIGITS + 1),
    localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
    localparam int SEL_W      = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    localparam int VAL_W      = $clog2(MAX_VALUE + 1),
    localparam int ACC_W      = $clog2(10 ** N_DIGITS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [4:0]                  digito,
    input  logic                        cambio_digito,
    output logic [5*N_DIGITS-1:0]       entry_digits,
    output logic [CNT_W-1:0]            entry_count,
    output logic                        entry_full,
    output logic [SEL_W-1:0]            chan_sel,
    output logic [VAL_W*N_CHANNELS-1:0] chan_values,
    output logic [N_CHANNELS-1:0]       chan_valid,
    output logic                        all_valid,
    output logic                        busy,
    output logic                        commit_pulse,
    output logic                        err_pulse
);

    // cambio_digito is a one-cycle strobe with no back-pressure: the key is
    // consumed only in S_ENTRY; strobes arriving while busy are dropped.
    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_load;
    logic [3:0]       cur_digit;
    logic             do_push, do_cancel, start_conv, clear_entry;
`ifdef BACKSPACE_EN
    logic             do_bksp;
`endif

    digit_shift_reg #(.N_DIGITS(N_DIGITS)) u_shift (
        .clk        (clk),
        .reset      (reset),
        .shift_up   (do_push),
        .digit_in   (digito[3:0]),
`ifdef BACKSPACE_EN
        .shift_down (do_bksp),
`endif
        .clear      (clear_entry),
        .digits     (entry_digits),
        .count      (entry_count)
    );

    assign entry_full  = (entry_count == CNT_W'(N_DIGITS));
    assign busy        = (state_q != S_ENTRY);
    assign all_valid   = &chan_valid;
    assign clear_entry = do_cancel || (state_q == S_CHECK);
    assign idx_load    = IDX_W'(entry_count - CNT_W'(1));

    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) cur_digit = entry_digits[5*i +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_ENTRY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        do_push    = 1'b0;
        do_cancel  = 1'b0;
        start_conv = 1'b0;
`ifdef BACKSPACE_EN
        do_bksp    = 1'b0;
`endif
        case (state_q)
            S_ENTRY: begin
                if (cambio_digito) begin
                    if (digito <= KEY_DIGIT_MAX) begin
                        do_push = !entry_full;
                    end else if (digito == KEY_CANCEL) begin
                        do_cancel = 1'b1;
                    end else if (digito == KEY_ENTER && entry_count != '0) begin
                        start_conv = 1'b1;
                        state_d    = S_CONV;
                    end
`ifdef BACKSPACE_EN
                    else if (digito == KEY_BKSP && entry_count != '0) begin
                        do_bksp = 1'b1;
                    end
`endif
                end
            end
            S_CONV:  if (idx_q == '0) state_d = S_CHECK;
            S_CHECK: state_d = S_ENTRY;
            default: state_d = S_ENTRY;
        endcase
    end

    // Converter and channel bank; pulses are registered on the S_CHECK edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q        <= '0;
            idx_q        <= '0;
            chan_sel     <= '0;
            chan_values  <= '0;
            chan_valid   <= '0;
            commit_pulse <= 1'b0;
            err_pulse    <= 1'b0;
        end else begin
            commit_pulse <= 1'b0;
            err_pulse    <= 1'b0;
            case (state_q)
                S_ENTRY: begin
                    if (start_conv) begin
                        acc_q <= '0;
                        idx_q <= idx_load;
                    end
                end
                S_CONV: begin
                    acc_q <= acc_q * ACC_W'(10) + ACC_W'(cur_digit);
                    idx_q <= idx_q - IDX_W'(1);
                end
                S_CHECK: begin
                    if (acc_q <= ACC_W'(MAX_VALUE)) begin
                        for (int k = 0; k < N_CHANNELS; k++) begin
                            if (chan_sel == SEL_W'(k)) begin
                                chan_values[VAL_W*k +: VAL_W] <= acc_q[VAL_W-1:0];
                                chan_valid[k]                 <= 1'b1;
                            end
                        end
                        if (chan_sel == SEL_W'(N_CHANNELS - 1)) chan_sel <= '0;
                        else                                    chan_sel <= chan_sel + SEL_W'(1);
                        commit_pulse <= 1'b1;
                    end else begin
                        err_pulse <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_entry_buffer.sv
// Directed bench for digit_entry_buffer with an expected-result queue for conversions.
module tb_digit_entry_buffer;
    import digit_entry_buffer_pkg::*;

    localparam logic [14:0] EMPTY = {3{5'd16}};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  digito = 5'd16;
    logic        cambio_digito = 1'b0;
    logic [14:0] entry_digits;
    logic [1:0]  entry_count;
    logic        entry_full;
    logic [1:0]  chan_sel;
    logic [23:0] chan_values;
    logic [2:0]  chan_valid;
    logic        all_valid, busy, commit_pulse, err_pulse;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    logic [23:0] model_vals;
    logic [2:0]  model_valid;
    int          model_sel;
    int          n_typed;
    bit          saw_pulse;

    digit_entry_buffer dut (
        .clk(clk), .reset(reset), .digito(digito), .cambio_digito(cambio_digito),
        .entry_digits(entry_digits), .entry_count(entry_count), .entry_full(entry_full),
        .chan_sel(chan_sel), .chan_values(chan_values), .chan_valid(chan_valid),
        .all_valid(all_valid), .busy(busy), .commit_pulse(commit_pulse), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press_key(input logic [4:0] k);
        @(negedge clk);
        digito = k;
        cambio_digito = 1'b1;
        @(negedge clk);
        cambio_digito = 1'b0;
        digito = KEY_BLANK;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_vals = '0;
        model_valid = '0;
        model_sel = 0;
        exp_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_digits"}, entry_digits, EMPTY);
        check({tag, "_count"}, entry_count, 0);
        check({tag, "_full"}, entry_full, 0);
        check({tag, "_sel"}, chan_sel, 0);
        check({tag, "_values"}, chan_values, 0);
        check({tag, "_valid"}, chan_valid, 0);
        check({tag, "_all_valid"}, all_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pulses"}, {commit_pulse, err_pulse}, 0);
    endtask

    task automatic type_number(input int v, output int n);
        int d[$];
        int t;
        t = v;
        if (t == 0) d.push_back(0);
        while (t > 0) begin
            d.push_front(t % 10);
            t = t / 10;
        end
        n = d.size();
        foreach (d[i]) press_key(5'(d[i]));
    endtask

    task automatic push_expect(input int v);
        logic [15:0] item;
        item = '0;
        item[15] = (v > 255);
        item[9:0] = v[9:0];
        exp_q.push_back(item);
    endtask

    // Entered at the negedge that is `start` cycles after the Enter edge.
    task automatic wait_result(input int n, input int start);
        logic [15:0] e;
        int j;
        bit got;
        e = exp_q.pop_front();
        got = 0;
        j = start;
        while (!got && j < start + 20) begin
            @(negedge clk);
            j++;
            if (commit_pulse === 1'b1 || err_pulse === 1'b1) got = 1;
        end
        check("result_seen", got, 1);
        if (got) begin
            check("latency", j, n + 1);
            check("err_pulse", err_pulse, e[15]);
            check("commit_pulse", commit_pulse, !e[15]);
            if (!e[15]) begin
                model_vals[8*model_sel +: 8] = e[7:0];
                model_valid[model_sel] = 1'b1;
                model_sel = (model_sel + 1) % 3;
            end
            check("chan_values", chan_values, model_vals);
            check("chan_valid", chan_valid, model_valid);
            check("chan_sel", chan_sel, model_sel);
            check("busy_after", busy, 0);
            check("entry_cleared", entry_digits, EMPTY);
            check("count_cleared", entry_count, 0);
            @(negedge clk);
            check("pulse_one_cycle", {commit_pulse, err_pulse}, 0);
        end
    endtask

    task automatic commit_number(input int v);
        int n;
        type_number(v, n);
        press_key(KEY_ENTER);
        check("busy_on_enter", busy, 1);
        push_expect(v);
        wait_result(n, 0);
    endtask

    initial begin
        model_vals = '0;
        model_valid = '0;
        model_sel = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_state("rst");

        press_key(5'd2); press_key(5'd5); press_key(5'd5);
        check("entry_255", entry_digits, {5'd2, 5'd5, 5'd5});
        check("count_255", entry_count, 3);
        check("full_255", entry_full, 1);
        press_key(KEY_ENTER);
        check("busy_255", busy, 1);
        push_expect(255);
        wait_result(3, 0);
        check("all_valid_partial", all_valid, 0);

        commit_number(300);

        press_key(5'd1); press_key(5'd2); press_key(5'd3); press_key(5'd4);
        check("entry_123", entry_digits, {5'd1, 5'd2, 5'd3});
        check("full_123", entry_full, 1);
        press_key(KEY_CANCEL);
        check("cancel_digits", entry_digits, EMPTY);
        check("cancel_count", entry_count, 0);
        press_key(KEY_BKSP);
        check("bksp_empty", entry_count, 0);
        press_key(5'd1); press_key(KEY_BLANK); press_key(5'd15);
        check("ignored_codes", entry_digits, {5'd16, 5'd16, 5'd1});
        press_key(KEY_CANCEL);
        press_key(KEY_ENTER);
        saw_pulse = 0;
        check("enter_empty_busy", busy, 0);
        repeat (6) begin
            @(negedge clk);
            if (commit_pulse !== 1'b0 || err_pulse !== 1'b0 || busy !== 1'b0) saw_pulse = 1;
        end
        check("enter_empty_quiet", saw_pulse, 0);

        apply_reset();
        check_reset_state("rst2");
        commit_number(7);
        commit_number(42);
        commit_number(0);
        check("ch1_42", chan_values[15:8], 42);
        check("all_valid", all_valid, 1);
        check("sel_wrap", chan_sel, 0);
        commit_number(9);

        press_key(5'd4); press_key(5'd5); press_key(KEY_BKSP);
`ifdef BACKSPACE_EN
        check("bksp_digits", entry_digits, {5'd16, 5'd16, 5'd4});
        check("bksp_count", entry_count, 1);
        press_key(5'd6); press_key(KEY_ENTER);
        push_expect(46);
        wait_result(2, 0);
`else
        check("bksp_digits", entry_digits, {5'd16, 5'd4, 5'd5});
        check("bksp_count", entry_count, 2);
        press_key(5'd6); press_key(KEY_ENTER);
        push_expect(456);
        wait_result(3, 0);
`endif

        type_number(123, n_typed);
        press_key(KEY_ENTER);
        press_key(5'd7);
        check("busy_drop", busy, 1);
        push_expect(123);
        wait_result(n_typed, 2);
        check("dropped_count", entry_count, 0);

        type_number(123, n_typed);
        press_key(KEY_ENTER);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_vals = '0;
        model_valid = '0;
        model_sel = 0;
        check_reset_state("rst_conv");
        saw_pulse = 0;
        repeat (6) begin
            @(negedge clk);
            if (commit_pulse !== 1'b0 || err_pulse !== 1'b0 || busy !== 1'b0) saw_pulse = 1;
        end
        check("rst_conv_quiet", saw_pulse, 0);
        check("rst_conv_values", chan_values, model_vals);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
